// File: rtl/stage3_execute.sv
// TCORE execute stage: ALU, combinational multiplier, branch/jump resolution
// and an iterative radix-2 restoring divider that freezes IF..EX while busy.
module stage3_execute #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            in1_sel_i,
  input  logic            in2_sel_i,
  input  logic [4:0]      alu_op_i,
  input  logic [2:0]      br_type_i,
  input  logic            jalr_i,
  output logic [XLEN-1:0] alu_result_o,
  output logic [XLEN-1:0] write_data_o,
  output logic [XLEN-1:0] pc_target_o,
  output logic            pc_sel_o,
  output logic            alu_stall_o
);

  localparam int CW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_PASSB = 5'd10;
  localparam logic [4:0] OP_MUL = 5'd11, OP_MULH = 5'd12, OP_MULHSU = 5'd13, OP_MULHU = 5'd14;
  localparam logic [4:0] OP_DIV = 5'd15, OP_DIVU = 5'd16, OP_REM = 5'd17, OP_REMU = 5'd18;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  div_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic            neg_quo_q, neg_rem_q, is_rem_q;

  logic [XLEN-1:0] op_a, op_b;
  assign op_a         = in1_sel_i ? pc_i : rs1_data_i;
  assign op_b         = in2_sel_i ? imm_i : rs2_data_i;
  assign write_data_o = rs2_data_i;

  logic            is_div_op, div_signed, div_rem, div_by_zero, div_overflow, div_start;
  logic [XLEN-1:0] abs_a, abs_b, special_result;

  assign is_div_op    = alu_op_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign div_signed   = (alu_op_i == OP_DIV) || (alu_op_i == OP_REM);
  assign div_rem      = (alu_op_i == OP_REM) || (alu_op_i == OP_REMU);
  assign div_by_zero  = (op_b == '0);
  assign div_overflow = div_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign abs_a        = (div_signed && op_a[XLEN-1]) ? -op_a : op_a;
  assign abs_b        = (div_signed && op_b[XLEN-1]) ? -op_b : op_b;

  // Zero-divisor and overflow results follow the RISC-V M rules and never stall.
  always_comb begin
    special_result = '0;
    if (div_by_zero)
      special_result = div_rem ? op_a : '1;
    else if (div_overflow)
      special_result = div_rem ? '0 : op_a;
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: if (is_div_op && !div_by_zero && !div_overflow) begin
        div_start = 1'b1;
        state_d   = BUSY;
      end
      BUSY: if (cnt_q == CW'(XLEN-1)) state_d = DONE;
      DONE: if (!stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d   = IDLE;
      div_start = 1'b0;
    end
  end

  assign alu_stall_o = !rst_i && !flush_i && (div_start || state_q == BUSY);

  // One restoring step: shift the next dividend bit into the partial remainder.
  logic [XLEN:0]   shifted;
  logic            sub_ok;
  logic [XLEN-1:0] trial;
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign sub_ok  = (shifted >= {1'b0, dvs_q});
  assign trial   = shifted[XLEN-1:0] - dvs_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (div_start) begin
        cnt_q     <= '0;
        quo_q     <= abs_a;
        rem_q     <= '0;
        dvs_q     <= abs_b;
        neg_quo_q <= div_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
        neg_rem_q <= div_signed && op_a[XLEN-1];
        is_rem_q  <= div_rem;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CW'(1);
        rem_q <= sub_ok ? trial : shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], sub_ok};
      end
    end
  end

  logic [XLEN-1:0] div_result;
  assign div_result = is_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                               : (neg_quo_q ? -quo_q : quo_q);

  // Multiply as a 33x33 signed product; the extension bit picks signed/unsigned.
  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN+1:0] prod;
  logic                     unused_prod_bits;
  assign mul_a = $signed({(alu_op_i == OP_MULH || alu_op_i == OP_MULHSU) && op_a[XLEN-1], op_a});
  assign mul_b = $signed({(alu_op_i == OP_MULH) && op_b[XLEN-1], op_b});
  assign prod  = (2*XLEN+2)'(mul_a) * (2*XLEN+2)'(mul_b);
  assign unused_prod_bits = ^prod[2*XLEN+1:2*XLEN];

  logic [4:0] shamt;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_result_o = '0;
    if (state_q == DONE) begin
      alu_result_o = div_result;
    end else begin
      case (alu_op_i)
        OP_ADD:    alu_result_o = op_a + op_b;
        OP_SUB:    alu_result_o = op_a - op_b;
        OP_SLL:    alu_result_o = op_a << shamt;
        OP_SLT:    alu_result_o = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
        OP_SLTU:   alu_result_o = {{(XLEN-1){1'b0}}, op_a < op_b};
        OP_XOR:    alu_result_o = op_a ^ op_b;
        OP_SRL:    alu_result_o = op_a >> shamt;
        OP_SRA:    alu_result_o = $signed(op_a) >>> shamt;
        OP_OR:     alu_result_o = op_a | op_b;
        OP_AND:    alu_result_o = op_a & op_b;
        OP_PASSB:  alu_result_o = op_b;
        OP_MUL:    alu_result_o = prod[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: alu_result_o = prod[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_result_o = special_result;
        default:   alu_result_o = '0;
      endcase
    end
  end

  // Branch conditions always compare the raw register operands.
  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (br_type_i)
      3'd1: br_taken = (rs1_data_i == rs2_data_i);
      3'd2: br_taken = (rs1_data_i != rs2_data_i);
      3'd3: br_taken = ($signed(rs1_data_i) < $signed(rs2_data_i));
      3'd4: br_taken = ($signed(rs1_data_i) >= $signed(rs2_data_i));
      3'd5: br_taken = (rs1_data_i < rs2_data_i);
      3'd6: br_taken = (rs1_data_i >= rs2_data_i);
      3'd7: br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  logic [XLEN-1:0] target_sum;
  assign target_sum  = (jalr_i ? rs1_data_i : pc_i) + imm_i;
  assign pc_target_o = jalr_i ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
  assign pc_sel_o    = br_taken && !alu_stall_o;

endmodule
